// File: rtl/gray_pkg.sv
// Shared definitions for the Gray sequence monitor.
//   state_t  : monitor FSM state (ACQ, LOCK, RESYNC; encoding 2'd3 is illegal)
//   gray2bin : Gray-to-binary conversion at the maximum supported width (GMAX).
//              Zero-extended inputs convert correctly because the extra
//              upper bits contribute nothing to the XOR chain.
package gray_pkg;

  localparam int unsigned GMAX = 32;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCK   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
    logic [GMAX-1:0] b;
    b = '0;
    b[GMAX-1] = g[GMAX-1];
    for (int unsigned i = GMAX - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Parameterised combinational Gray-to-binary converter (N <= GMAX).
//   gray : N-bit Gray code input
//   bin  : N-bit binary equivalent
module gray2bin_n
  import gray_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  assign bin = N'(gray2bin(GMAX'(gray)));

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray counter sequence monitor.
// Samples the Gray counter one cycle after each advance strobe, converts it to
// binary and checks every step is +1 mod 2^N, keeping step/wrap/error
// statistics and a lock indication.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   gray_in    : Gray value from the counter
//   step       : advance strobe (same pulse that enables the counter)
//   clr_err    : synchronous clear of err_count / err_flag
//   bin_out    : binary value of the last sample
//   bin_valid  : one-cycle strobe, bin_out updated
//   step_count : samples taken (wraps)
//   wrap       : one-cycle strobe on a correct 2^N-1 -> 0 step
//   err_count  : bad steps, saturating
//   err_flag   : sticky error indicator
//   locked     : high while in LOCK
module gray_seq_monitor
  import gray_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      gray_in,
  input  logic              step,
  input  logic              clr_err,
  output logic [N-1:0]      bin_out,
  output logic              bin_valid,
  output logic [STEP_W-1:0] step_count,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_flag,
  output logic              locked
);

  state_t       state;
  logic         step_d;
  logic [3:0]   run;
  logic [3:0]   run_next;
  logic [N-1:0] sample;
  logic [N-1:0] expect_bin;
  logic         correct;
  logic         err_event;

  gray2bin_n #(.N(N)) u_conv (
    .gray (gray_in),
    .bin  (sample)
  );

  always_comb begin
    expect_bin = '0;
    correct    = 1'b0;
    err_event  = 1'b0;
    run_next   = '0;
    expect_bin = bin_out + N'(1);
    correct    = (sample == expect_bin);
    err_event  = step_d && ((state == LOCK) || (state == RESYNC)) && !correct;
    run_next   = run + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ACQ;
      step_d     <= 1'b0;
      run        <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_count <= '0;
      wrap       <= 1'b0;
      err_count  <= '0;
      err_flag   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // The counter advances on the step edge; its new value is stable one cycle later.
      step_d    <= step;
      bin_valid <= step_d;
      wrap      <= 1'b0;

      if (step_d) begin
        bin_out    <= sample;
        step_count <= step_count + STEP_W'(1);
      end

      // An error in the clearing cycle restarts the count at one rather than being lost.
      if (err_event) begin
        err_flag <= 1'b1;
        if (clr_err)
          err_count <= ERR_W'(1);
        else if (err_count != '1)
          err_count <= err_count + ERR_W'(1);
      end else if (clr_err) begin
        err_count <= '0;
        err_flag  <= 1'b0;
      end

      case (state)
        ACQ: begin
          if (step_d) begin
            state  <= LOCK;
            locked <= 1'b1;
          end
        end
        LOCK: begin
          if (step_d) begin
            if (correct) begin
              wrap <= (bin_out == '1);
            end else begin
              state  <= RESYNC;
              locked <= 1'b0;
              run    <= '0;
            end
          end
        end
        RESYNC: begin
          if (step_d) begin
            if (correct) begin
              wrap <= (bin_out == '1);
              if (run_next == 4'(LOCK_RUN)) begin
                state  <= LOCK;
                locked <= 1'b1;
                run    <= '0;
              end else begin
                run <= run_next;
              end
            end else begin
              run <= '0;
            end
          end
        end
        default: begin
          state  <= ACQ;
          locked <= 1'b0;
          run    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_monitor.sv
module tb_gray_seq_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        clr_err = 1'b0;
  logic [3:0]  gray_in = '0;

  logic [3:0]  bin_out;
  logic        bin_valid;
  logic [15:0] step_count;
  logic        wrap;
  logic [7:0]  err_count;
  logic        err_flag;
  logic        locked;

  logic [3:0]  b_bin_out;
  logic        b_bin_valid;
  logic [3:0]  b_step_count;
  logic        b_wrap;
  logic [7:0]  b_err_count;
  logic        b_err_flag;
  logic        b_locked;

  always #5 clk = ~clk;

  gray_seq_monitor #(.N(4), .STEP_W(16), .ERR_W(8), .LOCK_RUN(2)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .step(step), .clr_err(clr_err),
    .bin_out(bin_out), .bin_valid(bin_valid), .step_count(step_count),
    .wrap(wrap), .err_count(err_count), .err_flag(err_flag), .locked(locked)
  );

  gray_seq_monitor #(.N(4), .STEP_W(4), .ERR_W(8), .LOCK_RUN(2)) dut4 (
    .clk(clk), .rst(rst), .gray_in(gray_in), .step(step), .clr_err(clr_err),
    .bin_out(b_bin_out), .bin_valid(b_bin_valid), .step_count(b_step_count),
    .wrap(b_wrap), .err_count(b_err_count), .err_flag(b_err_flag), .locked(b_locked)
  );

  typedef struct {
    logic [3:0]  bin;
    logic [15:0] sc;
    logic [3:0]  sc4;
    logic        wr;
    logic [7:0]  ec;
    logic        ef;
    logic        lk;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   nvec = 0;
  int   nmis = 0;
  int   nwrap = 0;

  // reference model state
  int   mstate = 0;  // 0 acquire, 1 locked, 2 resync
  int   mprev = 0;
  int   mrun = 0;
  int   mstep = 0;
  int   merr = 0;
  logic mflag = 1'b0;
  logic lastst = 1'b0;
  int   curb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_sample(input int b);
    exp_t x;
    logic ok;
    logic wr;
    wr = 1'b0;
    mstep++;
    if (mstate == 0) begin
      mstate = 1;
    end else begin
      ok = (b == ((mprev + 1) % 16));
      wr = ok && (mprev == 15);
      if (!ok) begin
        if (merr < 255) merr++;
        mflag = 1'b1;
        mrun = 0;
        mstate = 2;
      end else if (mstate == 2) begin
        mrun++;
        if (mrun == 2) begin
          mstate = 1;
          mrun = 0;
        end
      end
    end
    mprev = b;
    x.bin = 4'(b);
    x.sc  = 16'(mstep % 65536);
    x.sc4 = 4'(mstep % 16);
    x.wr  = wr;
    x.ec  = 8'(merr);
    x.ef  = mflag;
    x.lk  = (mstate == 1);
    q.push_back(x);
  endtask

  // One clock cycle of stimulus; b is the binary value the counter shows this cycle.
  task automatic drive(input logic s, input int b, input logic r, input logic c);
    step    = s;
    gray_in = 4'(b ^ (b >> 1));
    rst     = r;
    clr_err = c;
    if (!r) begin
      mstate = 0; mprev = 0; mrun = 0; mstep = 0; merr = 0; mflag = 1'b0;
    end else begin
      if (c) begin
        merr = 0;
        mflag = 1'b0;
      end
      if (lastst) model_sample(b);
    end
    lastst = r & s;
    @(negedge clk);
  endtask

  task automatic step_to(input int b, input int gap);
    drive(1'b1, curb, 1'b1, 1'b0);
    curb = b;
    repeat (gap) drive(1'b0, curb, 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin"}, bin_out, 0);
    chk({tag, "_valid"}, bin_valid, 0);
    chk({tag, "_sc"}, step_count, 0);
    chk({tag, "_wrap"}, wrap, 0);
    chk({tag, "_ec"}, err_count, 0);
    chk({tag, "_ef"}, err_flag, 0);
    chk({tag, "_lk"}, locked, 0);
    chk({tag, "_sc4"}, b_step_count, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (wrap) nwrap++;
    if (bin_valid) begin
      chk("valid_has_expect", (q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bin_out", bin_out, e.bin);
        chk("step_count", step_count, e.sc);
        chk("wrap", wrap, e.wr);
        chk("err_count", err_count, e.ec);
        chk("err_flag", err_flag, e.ef);
        chk("locked", locked, e.lk);
        chk("b_valid", b_bin_valid, 1);
        chk("b_bin_out", b_bin_out, e.bin);
        chk("b_step_count", b_step_count, e.sc4);
        chk("b_wrap", b_wrap, e.wr);
        chk("b_err_count", b_err_count, e.ec);
        chk("b_err_flag", b_err_flag, e.ef);
        chk("b_locked", b_locked, e.lk);
      end
    end else begin
      if (q.size() != 0) chk("missing_valid", bin_valid, 1);
      if (wrap) chk("stray_wrap", wrap, 0);
    end
  end

  initial begin
    @(negedge clk);
    repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
    chk_zero("reset");

    // 20 correct steps, one every 4 cycles
    for (int k = 1; k <= 20; k++) begin
      step_to(k % 16, 3);
      if (k == 17) chk("sc4_after17", b_step_count, 1);
    end
    chk("sc_20", step_count, 20);
    chk("ec_20", err_count, 0);
    chk("ef_20", err_flag, 0);
    chk("lk_20", locked, 1);
    chk("wraps_20", nwrap, 1);
    chk("bin_20", bin_out, 4);

    // 5 back-to-back steps
    drive(1'b1, curb, 1'b1, 1'b0);
    for (int v = 5; v <= 8; v++) drive(1'b1, v, 1'b1, 1'b0);
    curb = 9;
    repeat (3) drive(1'b0, curb, 1'b1, 1'b0);
    chk("sc_b2b", step_count, 25);
    chk("bin_b2b", bin_out, 9);

    // skip 5 -> 7, stall in resync, then relock on 8, 9
    while (curb != 5) step_to((curb + 1) % 16, 2);
    step_to(7, 2);
    chk("skip_ec", err_count, 1);
    chk("skip_ef", err_flag, 1);
    chk("skip_lk", locked, 0);
    step_to(7, 2);
    chk("stall_ec", err_count, 2);
    chk("stall_lk", locked, 0);
    step_to(8, 2);
    chk("run1_lk", locked, 0);
    step_to(9, 2);
    chk("relock_lk", locked, 1);
    chk("relock_ec", err_count, 2);

    // saturate with 300 stalls
    repeat (300) drive(1'b1, curb, 1'b1, 1'b0);
    repeat (2) drive(1'b0, curb, 1'b1, 1'b0);
    chk("sat_ec", err_count, 255);
    chk("sat_ef", err_flag, 1);

    // clear without error, then clear colliding with an error
    drive(1'b0, curb, 1'b1, 1'b1);
    chk("clr_ec", err_count, 0);
    chk("clr_ef", err_flag, 0);
    drive(1'b1, curb, 1'b1, 1'b0);
    drive(1'b0, curb, 1'b1, 1'b1);
    chk("clr_err_ec", err_count, 1);
    chk("clr_err_ef", err_flag, 1);
    drive(1'b0, curb, 1'b1, 1'b0);

    // reset with a sample in flight
    drive(1'b1, curb, 1'b1, 1'b0);
    curb = (curb + 1) % 16;
    drive(1'b0, curb, 1'b0, 1'b0);
    chk_zero("midrst");
    repeat (2) drive(1'b0, curb, 1'b1, 1'b0);
    chk("midrst_quiet", bin_valid, 0);
    step_to((curb + 6) % 16, 2);
    chk("ref_bin", bin_out, 4'((curb) % 16));
    chk("ref_ec", err_count, 0);
    chk("ref_ef", err_flag, 0);
    chk("ref_lk", locked, 1);
    chk("ref_sc", step_count, 1);

    repeat (3) drive(1'b0, curb, 1'b1, 1'b0);
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/gray_seq_monitor.md
Name: gray_seq_monitor

Overview:
- Downstream consumer of the N-bit Gray counter output and its advance strobe.
- Samples each new Gray value, converts it to binary, and checks that every step is exactly +1 (mod 2^N).
- Keeps step, wrap and error statistics and a lock indication, which the board-level system drives onto status LEDs.

Parameters:
- N, 4: width of the Gray input and binary output.
- STEP_W, 16: width of the step counter.
- ERR_W, 8: width of the saturating error counter.
- LOCK_RUN, 2: consecutive correct steps required to re-enter lock after an error (legal range 1..15).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-low.
- gray_in  in  N  Gray code value from the counter.
- step  in  1  one-cycle advance strobe, the same pulse that enables the counter.
- clr_err  in  1  synchronous clear of err_count and err_flag.
- bin_out  out  N  binary equivalent of the last sampled Gray value.
- bin_valid  out  1  one-cycle strobe: bin_out updated.
- step_count  out  STEP_W  number of samples taken; wraps.
- wrap  out  1  one-cycle strobe when a correct step goes from 2^N-1 to 0.
- err_count  out  ERR_W  number of bad steps; saturates at all-ones.
- err_flag  out  1  sticky error indicator.
- locked  out  1  high in state LOCK.

Behaviour:
- Reset: rst sampled low at a rising edge clears all outputs and internal registers to 0 and sets the state to ACQ.
- Reset mid-operation discards any sample in flight.
- Sampling: the counter updates on the edge where step=1, so gray_in is registered on the edge one cycle after step (step delayed by one flop).
- Conversion: gray_in is converted to binary, b[N-1]=g[N-1], b[i]=b[i+1]^g[i], registered.
  - Latency: step at cycle t -> bin_out/bin_valid at t+2.
  - Throughput: one sample per cycle; back-to-back step pulses are accepted.
- Per sample (bin_valid=1), with prev = previous bin_out and exp = prev+1 mod 2^N:
  - step_count increments and wraps at 2^STEP_W.
  - ACQ: take the sample as reference, no check, go to LOCK. locked=0.
  - LOCK: sample==exp -> stay in LOCK.
  - LOCK: sample!=exp (stall, skip or backward) -> error event, go to RESYNC with run=0.
  - RESYNC: sample==exp -> run+1; when run+1==LOCK_RUN go to LOCK.
  - RESYNC: sample!=exp -> error event, run=0.
  - Every sample becomes the new prev, whether correct or not.
- Error event:
  - err_count+1, saturating at 2^ERR_W-1.
  - err_flag=1, sticky.
  - Outputs update in the same cycle as bin_valid.
- wrap: asserted with bin_valid when prev==2^N-1, sample==0, and the step is correct. Never asserted in ACQ.
- clr_err:
  - Zeroes err_count and err_flag at the next edge.
  - If an error event occurs in the same cycle, the result is err_count=1, err_flag=1 (the event is never lost).
  - Does not affect the state or step_count.
- step while rst is low: ignored.
- No output is X after reset. All outputs are registered.

Decomposition:
- Shared package (gray_pkg):
  - State encoding localparams: ACQ=2'd0, LOCK=2'd1, RESYNC=2'd2. Encoding 2'd3 is illegal and recovers to ACQ.
  - gray2bin function definition.
- One sub-module: gray2bin_n, a parameterised N-bit combinational Gray-to-binary converter, instantiated once ahead of the output register.
- The FSM, counters and strobes live in gray_seq_monitor.

Test Plan:
- Reset then 20 correct steps (gray 0,1,3,2,6,...), step every 4 cycles, N=4:
  - bin_out follows 1..15,0,1,2,3,4 with latency 2 cycles.
  - step_count=20, one wrap pulse (15->0), locked=1 from the 1st sample on, err_count=0.
- Back-to-back step on 5 consecutive cycles with gray_in changing each cycle -> 5 bin_valid pulses on consecutive cycles, values correct.
- Inject a skip (binary 5 -> 7) while locked:
  - err_count=1, err_flag=1, locked=0.
  - With LOCK_RUN=2, after 8 and 9 arrive locked=1 again.
  - A stall (7 -> 7) during RESYNC gives err_count=2.
- 300 forced error samples with ERR_W=8 -> err_count saturates at 255. Then clr_err with no error -> 0/0. clr_err in the same cycle as an error -> err_count=1, err_flag=1.
- Assert rst low for 1 cycle mid-stream, with a step one cycle earlier -> no bin_valid produced for that step, all outputs 0, state ACQ. The next sample is taken as reference with no error.
- step_count width check with STEP_W=4: 17 samples -> step_count=1.
